// File: rtl/spfifo_pkg.sv
// Shared types, sizes and grant decode for the single-port-RAM FIFO stream port.
package spfifo_pkg;

    // Output buffer depth and the counter wide enough to hold 0..OUT_DEPTH.
    localparam int unsigned OUT_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;

    // Read-latency down-counter width; holds RD_LAT-1 for RD_LAT up to 3.
    localparam int unsigned LAT_W     = 2;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_REQ  = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2
    } rd_state_t;

    // Controller granted a write this cycle.
    function automatic logic wr_grant(input logic en, input logic write_en);
        return en & write_en;
    endfunction

    // Controller granted a read this cycle.
    function automatic logic rd_grant(input logic en, input logic write_en);
        return en & ~write_en;
    endfunction

endpackage

// File: rtl/spfifo_out_buf.sv
// Two-entry output FIFO holding RAM read words until the consumer takes them.
module spfifo_out_buf
    import spfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]      cnt
);

    logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Pops of an empty buffer and pushes into a full one (without a pop) are ignored.
    assign do_pop  = pop & (cnt != '0);
    assign do_push = push & ((cnt != CNT_W'(OUT_DEPTH)) | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/spfifo_stream_port.sv
// Valid/ready stream front end that turns producer and consumer handshakes into
// single w_bit/r_bit requests for the single-port-RAM FIFO controller.
module spfifo_stream_port
    import spfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  w_bit,
    output logic                  r_bit,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  en,
    input  logic                  write_en,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    wr_state_t        w_state;
    rd_state_t        r_state;
    logic [LAT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] buf_cnt;
    logic             wgnt;
    logic             rgnt;
    logic             push;
    logic             pop;

    // Grants are driven off the falling edge, so they are stable here.
    assign wgnt = wr_grant(en, write_en);
    assign rgnt = rd_grant(en, write_en);

    // Held low during reset; otherwise a function of write state and full only.
    assign s_ready = rst_n & (w_state == W_IDLE) & ~full;

    // Read word lands in the buffer on the last latency cycle.
    assign push = (r_state == R_WAIT) & (lat_cnt == '0);

    assign m_valid = (buf_cnt != '0);
    assign pop     = m_valid & m_ready;

    // Write FSM: capture one producer word, hold it on ram_din until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_bit   <= 1'b0;
            ram_din <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_valid && s_ready) begin
                        ram_din <= s_data;
                        w_bit   <= 1'b1;
                        w_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (wgnt) begin
                        w_bit   <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_bit   <= 1'b0;
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: request only when the buffer has room for the word in flight,
    // then count out the RAM latency before pushing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_bit   <= 1'b0;
            lat_cnt <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!empty && (buf_cnt < CNT_W'(OUT_DEPTH))) begin
                        r_bit   <= 1'b1;
                        r_state <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (rgnt) begin
                        r_bit   <= 1'b0;
                        lat_cnt <= LAT_W'(RD_LAT - 1);
                        r_state <= R_WAIT;
                    end else if (empty) begin
                        r_bit   <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                R_WAIT: begin
                    if (lat_cnt == '0) begin
                        r_state <= R_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: begin
                    r_bit   <= 1'b0;
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Output buffer; head entry drives m_data.
    spfifo_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (ram_dout),
        .pop   (pop),
        .dout  (m_data),
        .cnt   (buf_cnt)
    );

endmodule
